// File: rtl/dff_share_arb.sv
// -----------------------------------------------------------------------------
// dff_share_arb
//
// Round-robin arbiter that owns a single shared DW-bit register. Each clock
// edge with at least one request, one client is picked, its write-data lane
// is captured into the shared register, and a one-hot grant is returned for
// the following cycle.
//
// Optional feature macro: RR_LOCK_EN
//   When defined, the current owner can keep ownership by holding lock for up
//   to LOCK_MAX consecutive grants before round-robin is forced again.
//
// Ports:
//   clk      - rising-edge clock
//   rstn     - asynchronous reset, active low
//   req      - per-client request
//   lock     - per-client ownership hold request (RR_LOCK_EN builds only)
//   wdata    - packed write data, client i uses [i*DW +: DW]
//   gnt      - registered one-hot grant, zero when idle
//   owner    - index of the last granted client
//   q        - shared register contents
//   q_valid  - set by the first write, cleared only by reset
// -----------------------------------------------------------------------------
module dff_share_arb #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*DW-1:0]       wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic [DW-1:0]            q,
    output logic                     q_valid
);

    localparam int PW = $clog2(NREQ);

`ifdef RR_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX) + 1;
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
`else
    typedef enum logic {IDLE, GRANT} state_t;
`endif

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   next_ptr;
    logic [PW-1:0]   rr_win;
    logic            rr_found;
    logic [PW-1:0]   win;
    logic            hold_lock;
    logic            any_req;

    assign any_req = |req;

    // Search from ptr upward with wraparound; the first requesting client wins.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!rr_found && req[(int'(ptr) + k) % NREQ]) begin
                rr_found = 1'b1;
                rr_win   = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

`ifdef RR_LOCK_EN
    logic [CW-1:0] lock_cnt;

    // The owner keeps the register only if it was granted on the previous
    // edge, still requests and locks, and has not used up its lock budget.
    assign hold_lock = (state != IDLE) && req[owner] && lock[owner] &&
                       (lock_cnt != CW'(LOCK_MAX - 1));

    // Counts consecutive locked grants; any unlocked grant or idle edge clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_cnt <= '0;
        end else if (any_req && hold_lock) begin
            lock_cnt <= lock_cnt + CW'(1);
        end else begin
            lock_cnt <= '0;
        end
    end
`else
    logic unused_lock;

    // Without locking, neither the lock input nor the FSM state has a reader.
    assign hold_lock   = 1'b0;
    assign unused_lock = ^{lock, state};
`endif

    // Pick the winner, the pointer that follows it and the next FSM state.
    // A locked grant keeps ptr where it is so round-robin resumes correctly.
    always_comb begin
        win        = hold_lock ? owner : rr_win;
        next_ptr   = ptr;
        next_state = IDLE;
        if (any_req) begin
            if (!hold_lock) begin
                next_ptr = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            end
`ifdef RR_LOCK_EN
            next_state = hold_lock ? LOCKED : GRANT;
`else
            next_state = GRANT;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Shared register, grant, owner and pointer update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt     <= '0;
            owner   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            ptr     <= '0;
        end else if (any_req) begin
            gnt     <= NREQ'(1) << win;
            owner   <= win;
            q       <= wdata[win*DW +: DW];
            q_valid <= 1'b1;
            ptr     <= next_ptr;
        end else begin
            gnt     <= '0;
        end
    end

endmodule

// File: tb/tb_dff_share_arb.sv
// -----------------------------------------------------------------------------
// tb_dff_share_arb
//
// Self-checking bench for dff_share_arb. A behavioural model tracks the
// expected grant, owner, register value and valid flag from the arbitration
// rules; every driven cycle is compared against it, and a set of directed
// scenarios also pins expected values with literal constants.
// Honours RR_LOCK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_dff_share_arb;

    localparam int NREQ     = 4;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 4;

    logic                clk   = 1'b0;
    logic                rstn  = 1'b0;
    logic [NREQ-1:0]     req   = '0;
    logic [NREQ-1:0]     lock  = '0;
    logic [NREQ*DW-1:0]  wdata = '0;
    logic [NREQ-1:0]     gnt;
    logic [1:0]          owner;
    logic [DW-1:0]       q;
    logic                q_valid;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_ptr;
    int m_owner;
    int m_q;
    int m_qv;
    int m_gnt;
    int m_busy;
    int m_streak;

    logic [NREQ-1:0] lockExp [10];

    dff_share_arb #(.NREQ(NREQ), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .owner   (owner),
        .q       (q),
        .q_valid (q_valid)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_ptr = 0; m_owner = 0; m_q = 0; m_qv = 0; m_gnt = 0; m_busy = 0; m_streak = 0;
    endtask

    // One arbitration edge, expressed directly from the rules.
    task automatic modelEdge();
        int  w;
        bit  locked;
        if (req == 0) begin
            m_gnt    = 0;
            m_busy   = 0;
            m_streak = 0;
        end else begin
            locked = 0;
`ifdef RR_LOCK_EN
            if (m_busy != 0 && req[m_owner] && lock[m_owner] && m_streak < LOCK_MAX - 1)
                locked = 1;
`endif
            if (locked) begin
                w = m_owner;
            end else begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                m_ptr = (w + 1) % NREQ;
            end
            m_gnt    = 1 << w;
            m_q      = int'(wdata[w*DW +: DW]);
            m_owner  = w;
            m_qv     = 1;
            m_streak = locked ? m_streak + 1 : 0;
            m_busy   = 1;
        end
    endtask

    task automatic checkOutput();
        checkVal("gnt",     32'(gnt),     32'(m_gnt));
        checkVal("owner",   32'(owner),   32'(m_owner));
        checkVal("q",       32'(q),       32'(m_q));
        checkVal("q_valid", 32'(q_valid), 32'(m_qv));
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, "_gnt"},   32'(gnt),     0);
        checkVal({tag, "_owner"}, 32'(owner),   0);
        checkVal({tag, "_q"},     32'(q),       0);
        checkVal({tag, "_qv"},    32'(q_valid), 0);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                                 input logic [NREQ*DW-1:0] wd);
        req   = r;
        lock  = l;
        wdata = wd;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        logic [NREQ-1:0]    r;
        logic [NREQ*DW-1:0] lanes;

        modelReset();
        $display("[TB] start");

        // Reset held two cycles with no requests
        repeat (2) @(posedge clk);
        #1;
        checkZero("in_reset");
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 4'b0000, 32'h5A5A5A5A);
            checkZero("idle_after_reset");
        end

        // Single requester, then idle hold
        applyStimulus(4'b0100, 4'b0000, 32'h00A50000);
        checkVal("single_gnt",   32'(gnt),     32'h4);
        checkVal("single_q",     32'(q),       32'hA5);
        checkVal("single_owner", 32'(owner),   2);
        checkVal("single_qv",    32'(q_valid), 1);
        applyStimulus(4'b0000, 4'b0000, 32'hFFFFFFFF);
        checkVal("hold_gnt", 32'(gnt), 0);
        checkVal("hold_q",   32'(q),   32'hA5);

        // Wrap and skip: pointer sits at 3, only clients 0 and 1 request
        applyStimulus(4'b0011, 4'b0000, 32'h44332211);
        checkVal("wrap_gnt0", 32'(gnt), 32'h1);
        checkVal("wrap_q0",   32'(q),   32'h11);
        applyStimulus(4'b0011, 4'b0000, 32'h44332211);
        checkVal("wrap_gnt1", 32'(gnt), 32'h2);

        // Move the pointer back to 0
        applyStimulus(4'b1000, 4'b0000, 32'h77000000);
        checkVal("to3_owner", 32'(owner), 3);

        // Full contention: strict rotation 0,1,2,3 twice
        lanes = 32'h13121110;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 4'b0000, lanes);
            checkVal("cont_gnt", 32'(gnt), 32'(1 << (i % 4)));
            checkVal("cont_q",   32'(q),   32'(8'h10 + (i % 4)));
        end

        // Lock scenario starts from idle with pointer at 0
        applyStimulus(4'b0000, 4'b0000, 32'h0);
`ifdef RR_LOCK_EN
        lockExp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                    4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        lockExp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001,
                    4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0011, 4'b0001, 32'h0000BBAA);
            checkVal("lock_gnt", 32'(gnt), 32'(lockExp[i]));
        end

        // Randomized traffic with occasional reset between edges
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) r = '0;
            applyStimulus(r, 4'($urandom_range(0, 15)), $urandom);
            if (i % 57 == 30) begin
                rstn = 1'b0;
                #1;
                checkZero("rand_reset");
                modelReset();
                #1;
                rstn = 1'b1;
            end
        end

        // Reset in the middle of contention, then lowest-index wins
        for (int i = 0; i < 3; i++)
            applyStimulus(4'b1111, 4'b0000, 32'hDDCCBBAA);
        rstn = 1'b0;
        #1;
        checkZero("mid_reset");
        modelReset();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        applyStimulus(4'b0110, 4'b0000, 32'h00EE9900);
        checkVal("post_reset_gnt",   32'(gnt),   32'h2);
        checkVal("post_reset_owner", 32'(owner), 1);
        checkVal("post_reset_q",     32'(q),     32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
